// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU and its instruction-side loader.
package cpu_pkg;

  localparam int unsigned INSTR_W = 8;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

  // Loader FSM states. StCsum is only reachable when PROGRAM_LOADER_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLen   = 3'd1,
    StData  = 3'd2,
    StCsum  = 3'd3,
    StRun   = 3'd4,
    StError = 3'd5
  } loader_state_t;

endpackage

// File: rtl/instr_ram.sv
// Instruction memory: 2^AW x DW, synchronous write, asynchronous read. Contents are never reset.
module instr_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write port: byte lands on the accepting edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed byte stream over valid/ready, writes it into the
// instruction RAM, then serves instructions for the CPU's PC while holding the CPU idle during
// loads. Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum
// byte and the ERROR state; without it load_error is tied low.
module program_loader
  import cpu_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = INSTR_W
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  input  logic [7:0]    PC,
  output logic [DW-1:0] instruction,
  output logic          cpu_run,
  output logic [AW:0]   prog_len,
  output logic          load_error
);

  // A length byte of zero encodes a full 2^AW-byte program.
  localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};

  loader_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   len_q, len_d;
  logic          ready_q;
  logic          run_q;
  logic          accept;
  logic          mem_we;
  logic          last_byte;
  logic [AW:0]   next_count;
  logic [DW-1:0] rdata;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
  logic          err_q;
`endif

  assign accept     = load_valid && ready_q;
  // addr doubles as the count of data bytes already written.
  assign next_count = {1'b0, addr_q} + (AW+1)'(1);
  assign last_byte  = (next_count == len_q);

  // Next-state, address, length and checksum updates; load_start overrides any accepted byte.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    mem_we  = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (load_start) begin
      state_d = StLen;
      addr_d  = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else if (accept) begin
      case (state_q)
        StLen: begin
          len_d   = (load_data == '0) ? FULL_LEN : (AW+1)'(load_data);
          state_d = StData;
        end
        StData: begin
          mem_we = 1'b1;
          // Wraps to 0 after a full-length load; the FSM leaves DATA on that same edge.
          addr_d = addr_q + AW'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d = csum_q + load_data;
          if (last_byte) begin
            state_d = StCsum;
          end
`else
          if (last_byte) begin
            state_d = StRun;
          end
`endif
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        StCsum: begin
          state_d = (load_data == csum_q) ? StRun : StError;
        end
`endif
        default: ;
      endcase
    end
  end

  // State and registered handshake/status outputs, all decoded from the next state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      ready_q <= (state_d == StLen) || (state_d == StData) || (state_d == StCsum);
      run_q   <= (state_d == StRun);
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running checksum and error flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= (state_d == StError);
    end
  end

  assign load_error = err_q;
`else
  assign load_error = 1'b0;
`endif

  instr_ram #(
    .AW(AW),
    .DW(DW)
  ) u_instr_ram (
    .clk  (CLK),
    .we   (mem_we),
    .waddr(addr_q),
    .wdata(load_data),
    .raddr(PC[AW-1:0]),
    .rdata(rdata)
  );

  assign load_ready  = ready_q;
  assign cpu_run     = run_q;
  assign prog_len    = len_q;
  // Bytes past the loaded program, and everything outside RUN, read as NOP.
  assign instruction = (run_q && ({1'b0, PC[AW-1:0]} < len_q)) ? rdata : DW'(NOP_INSTR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with a behavioural byte-array reference model.
module tb_program_loader;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic [7:0] PC = 8'h00;
  logic       load_ready;
  logic [7:0] instruction;
  logic       cpu_run;
  logic [8:0] prog_len;
  logic       load_error;

  int checks = 0;
  int failures = 0;

  // Reference model: what the CPU should be able to fetch.
  logic [7:0] ref_mem [256];
  int         ref_len = 0;
  bit         ref_run = 1'b0;
  bit         ref_err = 1'b0;
  logic [7:0] prog_q [$];

  always #5 CLK = ~CLK;

  program_loader #(
    .AW(8),
    .DW(8)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .PC         (PC),
    .instruction(instruction),
    .cpu_run    (cpu_run),
    .prog_len   (prog_len),
    .load_error (load_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_instr(input int pc);
    if (ref_run && pc < ref_len) return ref_mem[pc];
    return 8'h00;
  endfunction

  // All tasks start and end on a falling edge.
  task automatic sweep(input string tag);
    for (int p = 0; p < 256; p++) begin
      PC = 8'(p);
      #1;
      check($sformatf("%s[%0d]", tag, p), instruction, ref_instr(p));
      @(negedge CLK);
    end
    PC = 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b, input int max_gap);
    int waited = 0;
    int gap = int'($urandom_range(0, max_gap));
    load_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      load_data = 8'($urandom);
      @(negedge CLK);
    end
    load_valid = 1'b1;
    load_data  = b;
    while (load_ready !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (load_ready !== 1'b1) begin
      check("push_timeout", load_ready, 1);
      load_valid = 1'b0;
    end else begin
      @(negedge CLK);
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    load_valid = 1'($urandom_range(0, 1));
    load_data  = 8'($urandom);
    @(negedge CLK);
    load_start = 1'b0;
    load_valid = 1'b0;
    ref_run = 1'b0;
    ref_err = 1'b0;
    check("ready_after_start", load_ready, 1);
    check("run_after_start", cpu_run, 0);
    check("err_after_start", load_error, 0);
  endtask

  task automatic load_program(input bit do_start, input int max_gap,
                              input logic [7:0] trailer_delta);
    int n = prog_q.size();
    logic [7:0] sum = 8'h00;
    if (do_start) pulse_start();
    push_byte(8'(n), max_gap);
    ref_len = n;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) check("run_early", cpu_run, 0);
      push_byte(prog_q[i], max_gap);
      ref_mem[i] = prog_q[i];
      sum = 8'(sum + prog_q[i]);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("ready_csum", load_ready, 1);
    check("run_before_csum", cpu_run, 0);
    push_byte(8'(sum + trailer_delta), max_gap);
    ref_run = (trailer_delta == 8'h00);
    ref_err = !ref_run;
`else
    ref_run = 1'b1;
`endif
    load_valid = 1'b0;
    check("run_after_load", cpu_run, ref_run);
    check("err_after_load", load_error, ref_err);
    check("ready_after_load", load_ready, 0);
    check("prog_len", prog_len, ref_len);
  endtask

  // Offer bytes while the loader must refuse them.
  task automatic offer_ignored(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 8'($urandom);
      PC         = 8'($urandom);
      #1;
      check("ready_low", load_ready, 0);
      check("instr_idle_run", instruction, ref_instr(int'(PC)));
      @(negedge CLK);
    end
    load_valid = 1'b0;
    PC = 8'h00;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before 400000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    #3;
    check("rst_ready", load_ready, 0);
    check("rst_run", cpu_run, 0);
    check("rst_len", prog_len, 0);
    check("rst_err", load_error, 0);
    check("rst_instr", instruction, 8'h00);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    offer_ignored(6);

    // Basic load.
    prog_q = {8'h11, 8'h22, 8'h33};
    load_program(1'b1, 0, 8'h00);
    sweep("instr_basic");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Bad checksum trailer (0x65 instead of 0x66).
    load_program(1'b1, 0, 8'hFF);
    sweep("instr_bad_csum");
    pulse_start();
`endif

    // Full-length program, one byte per cycle.
    prog_q.delete();
    for (int i = 0; i < 256; i++) prog_q.push_back(8'(i));
    load_program(1'b1, 0, 8'h00);
    sweep("instr_full");

    // Random programs with gaps, then bytes offered in RUN must be ignored.
    for (int r = 0; r < 4; r++) begin
      int n = int'($urandom_range(1, 40));
      prog_q.delete();
      for (int i = 0; i < n; i++) prog_q.push_back(8'($urandom));
      load_program(1'b1, 3, 8'h00);
      sweep("instr_rand");
      offer_ignored(8);
      if (r == 0) sweep("instr_rand_after_offer");
    end

    // Abort mid-DATA with a valid byte in the same cycle.
    pulse_start();
    push_byte(8'd5, 1);
    push_byte(8'hA1, 1);
    ref_mem[0] = 8'hA1;
    push_byte(8'hA2, 1);
    ref_mem[1] = 8'hA2;
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hEE;
    #1;
    check("abort_ready_before", load_ready, 1);
    @(negedge CLK);
    load_start = 1'b0;
    load_valid = 1'b0;
    check("abort_ready_after", load_ready, 1);
    check("abort_run", cpu_run, 0);
    check("abort_instr", instruction, 8'h00);
    prog_q = {8'h5A, 8'hC3};
    load_program(1'b0, 2, 8'h00);
    sweep("instr_abort");

    // Asynchronous reset while running.
    PC = 8'h00;
    #1;
    check("instr_before_reset", instruction, ref_instr(0));
    #2;
    RESET = 1'b0;
    #1;
    check("areset_run", cpu_run, 0);
    check("areset_instr", instruction, 8'h00);
    check("areset_ready", load_ready, 0);
    check("areset_len", prog_len, 0);
    check("areset_err", load_error, 0);
    ref_run = 1'b0;
    ref_err = 1'b0;
    ref_len = 0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    sweep("instr_post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Instruction-side counterpart of the single-cycle CPU datapath. It receives a program as a byte stream over a valid/ready handshake, stores it in a 2^AW-byte instruction memory, and then serves `instruction` combinationally for the CPU's `PC`. While a load is in progress it holds the CPU idle through `cpu_run` and supplies NOPs.

## Interface
- `AW`, 8: address width; memory depth is 2^AW bytes, and `PC` is truncated to AW bits.
- `DW`, 8: instruction and data width. Fixed at 8 for this CPU.
- `CLK`  in  1  system clock. Same divided clock that drives the datapath.
- `RESET`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  single-cycle pulse; aborts any activity and begins a new load.
- `load_valid`  in  1  host byte valid.
- `load_data`  in  8  host byte.
- `load_ready`  out  1  loader can accept a byte.
- `PC`  in  8  program counter from the datapath.
- `instruction`  out  8  instruction to the datapath.
- `cpu_run`  out  1  high when a program is loaded and the CPU may run. Drives the datapath reset gating.
- `prog_len`  out  9  number of program bytes loaded, 1..256.
- `load_error`  out  1  checksum mismatch. Constant 0 without `PROGRAM_LOADER_CHECKSUM_EN`.

## Operation
- FSM states: IDLE, LEN, DATA, CSUM, RUN, ERROR. Reset enters IDLE.
- **Reset values:**
  - `load_ready`=0, `cpu_run`=0, `prog_len`=0, `load_error`=0, `instruction`=NOP.
  - Write address, count and checksum registers are cleared.
  - Memory contents are not cleared.
- **`load_start` (any state):** go to LEN on the next edge. Clear address, checksum and `load_error`. `cpu_run` drops on that same edge.
- **LEN:**
  - The first accepted byte is the length N; N=0 means 256.
  - Store N in `prog_len`, then go to DATA.
- **DATA:**
  - Each accepted byte is written to mem[addr], then addr increments.
  - The byte is added to an 8-bit modulo-256 checksum.
  - After the Nth byte, go to CSUM if checksum is enabled, otherwise go to RUN.
- **CSUM:** one accepted byte is compared with the running sum.
  - Equal: go to RUN.
  - Not equal: go to ERROR.
- **RUN:**
  - `cpu_run`=1 and `load_ready`=0.
  - `instruction` = mem[PC[AW-1:0]] when PC < `prog_len`, otherwise NOP.
- **ERROR:**
  - `load_error`=1, `cpu_run`=0, `load_ready`=0.
  - Exits only via `load_start` or reset.
- **IDLE:** `load_ready`=0. `instruction`=NOP.
- **`instruction` outside RUN:** always NOP.
- **Address wrap:** with N=256, addr wraps 255→0 after the final write. No further writes occur because the FSM leaves DATA.

## Timing
- **Handshake:**
  - A byte transfers on the rising `CLK` edge where `load_valid` && `load_ready`.
  - `load_ready` is a registered function of state: high in LEN, DATA and CSUM.
  - `load_valid` may stay high across consecutive bytes, giving one byte per cycle.
- **Memory write:** synchronous, on the accepting edge. The byte is readable combinationally from the next cycle.
- **Entering RUN:**
  - `cpu_run` rises on the edge that accepts the last data byte (or the checksum byte).
  - The CPU's first fetch sees mem[0] on the following cycle.
- **`load_start` together with an accepted byte:** `load_start` wins and the byte is discarded.
- **Reset asserted mid-load:** the FSM goes to IDLE immediately (asynchronous). Partially written bytes remain in memory but are unreachable because `prog_len`=0.
- **`PC` changes:** propagate to `instruction` combinationally. No added latency.

## Configuration
- **Macro:** `PROGRAM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - The CSUM state exists and the host must send a checksum byte after the N data bytes.
  - A mismatch causes ERROR, and `load_error` follows the ERROR state.
- **Undefined:**
  - The CSUM state and the checksum register are absent.
  - DATA goes straight to RUN, and `load_error` is tied to 0.

## Structure
- **Shared package `cpu_pkg`:**
  - `NOP_INSTR` = 8'h00.
  - The loader state enum type `loader_state_t`.
  - `INSTR_W` = 8.
- **Sub-module `instr_ram`:** 2^AW×8 RAM with a synchronous write port and an asynchronous read port. The FSM, count and checksum logic stay in `program_loader`.

## Test plan
- **Basic load:** reset, `load_start`, then bytes 0x03, 0x11, 0x22, 0x33, 0x66 (checksum enabled).
  - `cpu_run`=1 on the edge accepting 0x66.
  - PC=0,1,2 gives 0x11, 0x22, 0x33; PC=3 gives 0x00.
- **Bad checksum:** same sequence with trailer 0x65.
  - `load_error`=1 and `cpu_run`=0.
  - `instruction`=0x00 for every PC.
  - A subsequent `load_start` clears `load_error`.
- **Full length:** length byte 0x00 followed by 256 bytes of value i.
  - `prog_len`=256 and PC=255 gives 0xFF.
- **Back-pressure and gaps:** `load_valid` toggles randomly; `load_ready` low in IDLE and RUN.
  - Exactly N bytes are written in order.
  - Bytes offered in RUN are ignored and memory is unchanged.
- **Abort:** `load_start` asserted mid-DATA in the same cycle as a valid byte.
  - That byte is dropped and the state returns to LEN with address 0.
  - A new 2-byte program loads correctly.
- **Asynchronous reset in RUN:** `RESET` pulsed low between clock edges.
  - `cpu_run`=0 and `instruction`=0x00 immediately, with no clock edge required.
